// File: rtl/i2s_dsd_pkg.sv
// Shared widths, feedback levels and saturating arithmetic for the I2S-to-DSD path.
package i2s_dsd_pkg;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 24;
   localparam int SUM_W  = ACC_W + 2;

   localparam logic signed [ACC_W-1:0] FB_POS  = ACC_W'(2**(DATA_W-1));
   localparam logic signed [ACC_W-1:0] FB_NEG  = -FB_POS;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // a + b - c evaluated with two guard bits, then clamped to the accumulator range
   function automatic logic signed [ACC_W-1:0] sat_add3(
      input logic signed [ACC_W-1:0] a,
      input logic signed [ACC_W-1:0] b,
      input logic signed [ACC_W-1:0] c
   );
      logic signed [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b) - SUM_W'(c);
      if (s > SUM_W'(ACC_MAX))
         return ACC_MAX;
      else if (s < SUM_W'(ACC_MIN))
         return ACC_MIN;
      else
         return s[ACC_W-1:0];
   endfunction
endpackage

// File: rtl/i2s_dsd_top_dsm2.sv
// Second-order delta-sigma modulator, one channel. The output bit register lives
// in the top so it can be shared with the bypass path; it is fed back here.
module dsm2_mod
   import i2s_dsd_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic signed [DATA_W-1:0] x_i,
   input  logic                     fb_bit_i,
   output logic                     bit_d_o
);
   logic signed [ACC_W-1:0] i1_q, i1_d;
   logic signed [ACC_W-1:0] i2_q, i2_d;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] fb;

   always_comb begin
      x_ext   = ACC_W'(x_i);
      fb      = fb_bit_i ? FB_POS : FB_NEG;
      bit_d_o = ~i2_q[ACC_W-1];
      i1_d    = '0;
      i2_d    = '0;
      // Both integrators use pre-update values; disabled means held at zero.
      if (en_i) begin
         i1_d = sat_add3(i1_q, x_ext, fb);
         i2_d = sat_add3(i2_q, i1_q, fb);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         i1_q <= '0;
         i2_q <= '0;
      end else begin
         i1_q <= i1_d;
         i2_q <= i2_d;
      end
   end
endmodule

// File: rtl/i2s_dsd_top.sv
// I2S receiver feeding two second-order modulators, with a native-DSD bypass
// sharing the same pins. Everything runs on the incoming bit clock.
module i2s_dsd_top
   import i2s_dsd_pkg::*;
(
   input  logic I2S_BCKorDSDCLK,
   input  logic I2S_RST,
   input  logic I2S_LRCKorDSD2,
   input  logic I2S_DATAorDSD1,
   input  logic DSD_ON,
   output logic DSDCLK,
   output logic DSDLEFT,
   output logic DSDRIGHT
);
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] lat_l_q, lat_l_d;
   logic [DATA_W-1:0] lat_r_q, lat_r_d;
   logic              lr_prev_q;
   logic              dsd_l_q, dsd_l_d;
   logic              dsd_r_q, dsd_r_d;
   logic              mod_l_bit, mod_r_bit;

   assign DSDCLK   = ~I2S_BCKorDSDCLK;
   assign DSDLEFT  = dsd_l_q;
   assign DSDRIGHT = dsd_r_q;

   always_comb begin
      shift_d = {shift_q[DATA_W-2:0], I2S_DATAorDSD1};
      lat_l_d = lat_l_q;
      lat_r_d = lat_r_q;
      // A word-select change marks the bit on this edge as the LSB of the previous slot.
      if (I2S_LRCKorDSD2 != lr_prev_q) begin
         if (!lr_prev_q)
            lat_l_d = shift_d;
         else
            lat_r_d = shift_d;
      end
      dsd_l_d = DSD_ON ? mod_l_bit : I2S_DATAorDSD1;
      dsd_r_d = DSD_ON ? mod_r_bit : I2S_LRCKorDSD2;
   end

   always_ff @(posedge I2S_BCKorDSDCLK or posedge I2S_RST) begin
      if (I2S_RST) begin
         shift_q   <= '0;
         lat_l_q   <= '0;
         lat_r_q   <= '0;
         lr_prev_q <= 1'b0;
         dsd_l_q   <= 1'b0;
         dsd_r_q   <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         lat_l_q   <= lat_l_d;
         lat_r_q   <= lat_r_d;
         lr_prev_q <= I2S_LRCKorDSD2;
         dsd_l_q   <= dsd_l_d;
         dsd_r_q   <= dsd_r_d;
      end
   end

   dsm2_mod u_mod_l (
      .clk_i    (I2S_BCKorDSDCLK),
      .rst_i    (I2S_RST),
      .en_i     (DSD_ON),
      .x_i      ($signed(lat_l_q)),
      .fb_bit_i (dsd_l_q),
      .bit_d_o  (mod_l_bit)
   );

   dsm2_mod u_mod_r (
      .clk_i    (I2S_BCKorDSDCLK),
      .rst_i    (I2S_RST),
      .en_i     (DSD_ON),
      .x_i      ($signed(lat_r_q)),
      .fb_bit_i (dsd_r_q),
      .bit_d_o  (mod_r_bit)
   );
endmodule

// File: tb/tb_i2s_dsd_top.sv
// Bench for i2s_dsd_top: directed and random I2S frames and bypass data,
// checked cycle by cycle against an arithmetic model of the modulator equations.
module tb_i2s_dsd_top;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ws  = 1'b0;
   logic din = 1'b0;
   logic on  = 1'b1;
   logic dsdclk, dl, dr;

   int n_chk  = 0;
   int n_pass = 0;

   localparam longint AMAX = (64'sd1 <<< 23) - 1;
   localparam longint AMIN = -(64'sd1 <<< 23);
   localparam longint FB   = 32768;

   longint m_i1[2];
   longint m_i2[2];
   bit     m_out[2];
   int     m_lat[2];
   int     m_hist;
   bit     m_lrp;
   int     prev_r;

   i2s_dsd_top dut (
      .I2S_BCKorDSDCLK (clk),
      .I2S_RST         (rst),
      .I2S_LRCKorDSD2  (ws),
      .I2S_DATAorDSD1  (din),
      .DSD_ON          (on),
      .DSDCLK          (dsdclk),
      .DSDLEFT         (dl),
      .DSDRIGHT        (dr)
   );

   always #5 clk = ~clk;

   function automatic longint clamp(input longint v);
      if (v > AMAX) return AMAX;
      if (v < AMIN) return AMIN;
      return v;
   endfunction

   function automatic longint sx16(input int v);
      int u;
      u = v & 32'h0000FFFF;
      return (u >= 32768) ? longint'(u - 65536) : longint'(u);
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_i1[c]  = 0;
         m_i2[c]  = 0;
         m_out[c] = 1'b0;
         m_lat[c] = 0;
      end
      m_hist = 0;
      m_lrp  = 1'b0;
   endtask

   task automatic model_edge(input bit d, input bit w, input bit en);
      bit     nb[2];
      longint x, f, n1, n2;
      int     nh;
      for (int c = 0; c < 2; c++) begin
         x = sx16(m_lat[c]);
         f = m_out[c] ? FB : -FB;
         if (en) begin
            nb[c]   = (m_i2[c] >= 0);
            n1      = clamp(m_i1[c] + x - f);
            n2      = clamp(m_i2[c] + m_i1[c] - f);
            m_i1[c] = n1;
            m_i2[c] = n2;
         end else begin
            nb[c]   = (c == 0) ? d : w;
            m_i1[c] = 0;
            m_i2[c] = 0;
         end
      end
      m_out[0] = nb[0];
      m_out[1] = nb[1];
      nh = ((m_hist << 1) | int'(d)) & 32'h0000FFFF;
      if (w != m_lrp) m_lat[m_lrp] = nh;
      m_hist = nh;
      m_lrp  = w;
   endtask

   task automatic step(input bit d, input bit w, input bit en);
      din = d;
      ws  = w;
      on  = en;
      @(posedge clk);
      model_edge(d, w, en);
      #1;
      chk("dsdleft", dl, m_out[0]);
      chk("dsdright", dr, m_out[1]);
      chk("dsdclk_hi", dsdclk, ~clk);
   endtask

   // Standard I2S: word select leads the MSB by one bit clock; the previous
   // right LSB goes out in the first left-slot cycle.
   task automatic send_frame(input int l, input int r, input int off_lo, input int off_hi);
      bit d;
      for (int k = 0; k < 32; k++) begin
         if (k == 0)       d = prev_r[0];
         else if (k < 16)  d = l[16-k];
         else if (k == 16) d = l[0];
         else              d = r[32-k];
         step(d, (k >= 16), !(k >= off_lo && k <= off_hi));
      end
      prev_r = r;
   endtask

   initial begin
      model_reset();
      prev_r = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_left", dl, 1'b0);
      chk("rst_right", dr, 1'b0);
      chk("rst_dsdclk", dsdclk, ~clk);
      rst = 1'b0;

      repeat (8) step(1'b0, 1'b0, 1'b1);

      #2 rst = 1'b1;
      #1;
      chk("midrst_left", dl, 1'b0);
      chk("midrst_right", dr, 1'b0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      repeat (8) send_frame(32'h4000, 32'hC000, 99, 99);
      repeat (8) send_frame(32'h7FFF, 32'h8000, 99, 99);
      repeat (6) send_frame(32'h0001, 32'h8000, 99, 99);
      repeat (6) send_frame(int'($urandom), int'($urandom), 99, 99);

      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      #5;
      chk("dsdclk_lo", dsdclk, 1'b1);
      for (int i = 0; i < 20; i++)
         step(1'($urandom), 1'($urandom), 1'b0);

      repeat (4) send_frame(int'($urandom), int'($urandom), 99, 99);
      send_frame(int'($urandom), int'($urandom), 10, 13);
      send_frame(int'($urandom), int'($urandom), 20, 28);
      repeat (2) send_frame(int'($urandom), int'($urandom), 99, 99);
      for (int i = 0; i < 16; i++)
         step(1'($urandom), 1'($urandom), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
